// File: rtl/game_keys_in_if.sv
// game_keys_in_if: Avalon-MM slave signals plus the interrupt line of the key input port
interface game_keys_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport slave (input address, chipselect, write_n, writedata, output readdata, irq);
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
endinterface

// File: rtl/game_keys_in.sv
// game_keys_in: synchronised, debounced input PIO with edge capture and masked interrupt
module game_keys_in #(
    parameter int WIDTH = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE = 1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input logic clk,
    input logic reset_n,
    game_keys_in_if.slave bus,
    input logic [WIDTH-1:0] in_port
);
    localparam int CW = DEBOUNCE_CYCLES > 0 ? $clog2(DEBOUNCE_CYCLES) + 1 : 1;
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};
    logic [WIDTH-1:0] sync1, sync2, db, db_next, irqmask, edgecapture, edge_set, clr;
    logic wr;
    logic [31:0] rd_mux;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
            db <= IDLE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            db <= db_next;
        end
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign db_next = sync2;
        end else begin : g_debounce
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CW-1:0] cnt;
                logic done;
                assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
                assign db_next[i] = (sync2[i] != db[i] && done) ? sync2[i] : db[i];
                // any sample matching the current level restarts the stability count
                always_ff @(posedge clk or negedge reset_n)
                    if (!reset_n) cnt <= '0;
                    else cnt <= (sync2[i] == db[i] || done) ? '0 : cnt + 1'b1;
            end
        end
    endgenerate
    always_comb begin
        wr = bus.chipselect & ~bus.write_n;
        edge_set = EDGE_TYPE == 0 ? db_next & ~db : EDGE_TYPE == 1 ? ~db_next & db : db_next ^ db;
        clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
        rd_mux = bus.address == 2'd0 ? 32'(db) :
                 bus.address == 2'd1 ? 32'(irqmask) :
                 bus.address == 2'd3 ? 32'(edgecapture) : 32'h0;
    end
    // a new edge wins over a simultaneous write-1-to-clear of the same bit
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            irqmask <= '0;
            edgecapture <= '0;
            bus.readdata <= '0;
        end else begin
            if (wr && bus.address == 2'd1) irqmask <= bus.writedata[WIDTH-1:0];
            edgecapture <= (edgecapture & ~clr) | edge_set;
            bus.readdata <= bus.chipselect ? rd_mux : 32'h0;
        end
    assign bus.irq = |(edgecapture & irqmask);
endmodule

// File: tb/tb_game_keys_in.sv
// tb_game_keys_in: directed and random checks of game_keys_in against a sample-window model
module tb_game_keys_in;
    localparam int W = 4, D = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [W-1:0] keys = '1;
    int n_vec = 0, n_err = 0;
    logic [31:0] v;
    game_keys_in_if bus ();
    game_keys_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(keys));
    always #5 clk = ~clk;

    // model: a level flips once the last D synchronised samples all disagree with it
    logic [W-1:0] m_p0, m_p1, m_db, m_mask, m_ecap, m_s, m_nd, m_stable;
    logic [W-1:0] m_hist [D];
    logic [31:0] m_rd;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            m_p0 = '1;
            m_p1 = '1;
            m_db = '1;
            m_mask = '0;
            m_ecap = '0;
            m_rd = '0;
            for (int i = 0; i < D; i++) m_hist[i] = '1;
        end else begin
            m_s = m_p1;
            for (int i = D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_s;
            m_stable = '1;
            for (int i = 0; i < D; i++) m_stable = m_stable & (m_hist[i] ^ m_db);
            m_nd = m_db ^ m_stable;
            m_rd = !bus.chipselect ? 32'h0 : bus.address == 2'd0 ? 32'(m_db) :
                   bus.address == 2'd1 ? 32'(m_mask) : bus.address == 2'd3 ? 32'(m_ecap) : 32'h0;
            if (bus.chipselect && !bus.write_n && bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
            if (bus.chipselect && !bus.write_n && bus.address == 2'd3) m_ecap = m_ecap & ~bus.writedata[W-1:0];
            m_ecap = m_ecap | (m_db & ~m_nd);
            m_db = m_nd;
            m_p1 = m_p0;
            m_p0 = keys;
        end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("readdata", bus.readdata, m_rd);
        chk("irq", 32'(bus.irq), 32'(|(m_ecap & m_mask)));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.address = 2'd0;
        bus.writedata = 32'h0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        bus.address = a;
        bus.writedata = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r);
        bus.chipselect = 1'b1;
        bus.write_n = 1'b1;
        bus.address = a;
        step();
        r = bus.readdata;
        idle();
    endtask

    initial begin
        idle();
        steps(2);
        reset_n = 1'b1;
        rd(2'd0, v); chk("reset data", v, 32'h0000000F);
        rd(2'd3, v); chk("reset edgecapture", v, 32'h0);
        chk("reset irq", 32'(bus.irq), 32'h0);
        // glitch shorter than D samples
        keys[1] = 1'b0; steps(3); keys[1] = 1'b1; steps(8);
        rd(2'd0, v); chk("glitch data", v, 32'h0000000F);
        rd(2'd3, v); chk("glitch edgecapture", v, 32'h0);
        chk("glitch irq", 32'(bus.irq), 32'h0);
        // falling edge timing: readdata reflects db one edge late
        bus.chipselect = 1'b1;
        keys[0] = 1'b0;
        steps(6); chk("db before k+5", bus.readdata, 32'h0000000F);
        step(); chk("db after k+5", bus.readdata, 32'h0000000E);
        idle();
        rd(2'd3, v); chk("fall edgecapture", v, 32'h1);
        // interrupt path
        wr(2'd1, 32'h1); chk("irq on mask", 32'(bus.irq), 32'h1);
        wr(2'd3, 32'h1); chk("irq after w1c", 32'(bus.irq), 32'h0);
        rd(2'd3, v); chk("edgecapture after w1c", v, 32'h0);
        wr(2'd1, 32'h0);
        keys[0] = 1'b1; steps(8);
        keys[0] = 1'b0; steps(8);
        rd(2'd3, v); chk("recaptured", v, 32'h1);
        chk("masked irq", 32'(bus.irq), 32'h0);
        // edge and W1C on the same edge
        wr(2'd3, 32'hF);
        keys[2] = 1'b0; steps(5);
        wr(2'd3, 32'h4);
        rd(2'd3, v); chk("collision", v, 32'h4);
        // async reset in the middle of a debounce count
        wr(2'd1, 32'hF);
        keys[3] = 1'b0; steps(4);
        reset_n = 1'b0; step();
        chk("in-reset readdata", bus.readdata, 32'h0);
        chk("in-reset irq", 32'(bus.irq), 32'h0);
        reset_n = 1'b1;
        rd(2'd1, v); chk("mask after reset", v, 32'h0);
        rd(2'd0, v); chk("db after reset", v, 32'h0000000F);
        steps(2);
        rd(2'd3, v); chk("no early capture", v, 32'h0);
        steps(3);
        rd(2'd3, v); chk("capture after hold", v, 32'hD);
        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) keys = keys ^ (W'(1) << $urandom_range(W - 1));
            bus.chipselect = $urandom_range(3) != 0;
            bus.write_n = $urandom_range(3) != 0;
            bus.address = 2'($urandom_range(3));
            bus.writedata = $urandom;
            reset_n = $urandom_range(499) != 0;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
